mux: RTL and testbench

MUX -- requirements
Module: mux

---
 rtl/mux_if.sv | 42 ++++
 rtl/mux.sv | 68 ++++++
 tb/tb_mux.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mux_if
// Description : Data/select bundle for the registered 2:1 mux. The master
//               drives the operands and select; the slave returns the
//               combinational result, registered result, registered select
//               and the select-change counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_if #(
  parameter int w = 8
);
  logic [w-1:0] a;
  logic [w-1:0] b;
  logic         s;
  logic [w-1:0] c;
  logic [w-1:0] c_q;
  logic         s_q;
  logic [15:0]  sel_toggles;

  modport master (
    output a,
    output b,
    output s,
    input  c,
    input  c_q,
    input  s_q,
    input  sel_toggles
  );

  modport slave (
    input  a,
    input  b,
    input  s,
    output c,
    output c_q,
    output s_q,
    output sel_toggles
  );
endinterface
`default_nettype wire

// File: rtl/mux.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mux
// Description : 2:1 multiplexer with a purely combinational output, a
//               registered copy of the result, a registered select and a
//               saturating 16-bit count of edge-sampled select changes.
//               Reset is asynchronous and active-low; the combinational
//               path ignores reset entirely.
// Revision    : 1.0 - initial release
// ============================================================================
module mux #(
  parameter int w = 8
) (
  input  wire logic clk,
  input  wire logic rst_n,
  mux_if.slave      bus
);

  localparam logic [15:0] c_cnt_max = 16'hFFFF;

  logic [w-1:0] w_c;
  logic         w_sel_changed;
  logic         w_cnt_sat;
  logic [w-1:0] r_c_q;
  logic         r_s_q;
  logic [15:0]  r_sel_toggles;

  // Select between a and b with no clock or reset involvement; bit i of the
  // result always comes from bit i of the chosen operand.
  always_comb begin
    w_c = bus.s ? bus.a : bus.b;
  end

  // A change counts only when the select seen at this edge differs from the
  // one captured at the previous edge; glitches between edges never show up.
  always_comb begin
    w_sel_changed = (bus.s != r_s_q);
    w_cnt_sat     = (r_sel_toggles == c_cnt_max);
  end

  // Register the mux result and the select; cleared at once by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_q <= '0;
      r_s_q <= 1'b0;
    end else begin
      r_c_q <= w_c;
      r_s_q <= bus.s;
    end
  end

  // Count sampled select changes, holding at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_toggles <= 16'h0000;
    end else if (w_sel_changed && !w_cnt_sat) begin
      r_sel_toggles <= r_sel_toggles + 16'h0001;
    end
  end

  assign bus.c           = w_c;
  assign bus.c_q         = r_c_q;
  assign bus.s_q         = r_s_q;
  assign bus.sel_toggles = r_sel_toggles;

endmodule
`default_nettype wire

// File: tb/tb_mux.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mux
// Description : Directed self-checking bench for mux at w=8 and w=2, with a
//               scoreboard queue holding the registered results expected
//               after each clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux;

  logic clk;
  logic rst_n;

  mux_if #(.w(8)) bus8 ();
  mux_if #(.w(2)) bus2 ();

  mux #(.w(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  mux #(.w(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  // 40 ns clock period
  initial clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct {
    logic [7:0]  cq8;
    logic [1:0]  cq2;
    logic        sq;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic        m_sq;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance the select model as the DUT will at the next edge.
  task automatic model_edge(input logic s);
    if (s != m_sq && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
    m_sq = s;
  endtask

  task automatic push_exp(input logic [7:0] cq8, input logic [1:0] cq2);
    exp_t e;
    model_edge(bus8.s);
    e.cq8 = cq8;
    e.cq2 = cq2;
    e.sq  = m_sq;
    e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_cq8"}, 64'(bus8.c_q), 64'(e.cq8));
      chk({tag, "_cq2"}, 64'(bus2.c_q), 64'(e.cq2));
      chk({tag, "_sq"},  64'(bus8.s_q), 64'(e.sq));
      chk({tag, "_cnt"}, 64'(bus8.sel_toggles), 64'(e.cnt));
    end
  endtask

  // Drive one operand set at the falling edge, check c, then check the
  // registered outputs just after the following rising edge.
  task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [1:0] e2;
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.s = s;
    bus2.s = s;
    #1;
    e2 = s ? 2'b10 : 2'b01;
    chk({tag, "_c8"}, 64'(bus8.c), 64'(s ? a : b));
    chk({tag, "_c2"}, 64'(bus2.c), 64'(e2));
    push_exp(s ? a : b, e2);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  // Watchdog so the run always ends
  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ra, rb;
    logic       rs;
    rst_n  = 1'b0;
    bus8.a = 8'h00; bus8.b = 8'h00; bus8.s = 1'b0;
    bus2.a = 2'b10; bus2.b = 2'b01; bus2.s = 1'b0;
    m_sq   = 1'b0;
    m_cnt  = 16'h0;

    // Reset state before any clock edge
    #5;
    chk("rst_cq8", 64'(bus8.c_q), 64'h0);
    chk("rst_sq",  64'(bus8.s_q), 64'h0);
    chk("rst_cnt", 64'(bus8.sel_toggles), 64'h0);
    chk("rst_cq2", 64'(bus2.c_q), 64'h0);

    // Registers hold zero across an edge while reset is low
    bus8.a = 8'hA5; bus8.s = 1'b1; bus2.s = 1'b1;
    #1;
    chk("rst_c_live", 64'(bus8.c), 64'hA5);
    @(posedge clk); #1;
    chk("rst_hold_cq8", 64'(bus8.c_q), 64'h0);
    chk("rst_hold_cnt", 64'(bus8.sel_toggles), 64'h0);
    @(negedge clk);
    bus8.s = 1'b0; bus2.s = 1'b0;
    rst_n = 1'b1;

    // Truth-table style patterns; first edge with s=0 does not count
    step("p026", 8'h00, 8'hFF, 1'b0);
    step("p027", 8'h00, 8'hFF, 1'b1);
    step("p028", 8'hFF, 8'h00, 1'b0);
    step("p029", 8'hFF, 8'h00, 1'b1);
    step("hold", 8'h3C, 8'hC3, 1'b1);

    // Select toggling every 5 ns inside one period, settling back to the
    // previously sampled value: c follows every change, counter does not move
    @(negedge clk);
    bus8.a = 8'hFF; bus8.b = 8'h00;
    #1; bus8.s = 1'b0; bus2.s = 1'b0; #1;
    chk("tgl_c0", 64'(bus8.c), 64'h00);
    #4; bus8.s = 1'b1; bus2.s = 1'b1; #1;
    chk("tgl_c1", 64'(bus8.c), 64'hFF);
    #4; bus8.s = 1'b0; bus2.s = 1'b0; #1;
    chk("tgl_c2", 64'(bus8.c), 64'h00);
    chk("tgl_c2_w2", 64'(bus2.c), 64'h1);
    #4; bus8.s = 1'b1; bus2.s = 1'b1; #1;
    chk("tgl_c3", 64'(bus8.c), 64'hFF);
    push_exp(8'hFF, 2'b10);
    @(posedge clk); #1;
    pop_check("tgl");

    // Mid-run reset: registers clear without a clock edge, c keeps tracking
    @(negedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    chk("mid_cq8", 64'(bus8.c_q), 64'h0);
    chk("mid_sq",  64'(bus8.s_q), 64'h0);
    chk("mid_cnt", 64'(bus8.sel_toggles), 64'h0);
    bus8.s = 1'b0; bus2.s = 1'b0; #1;
    chk("mid_c_b", 64'(bus8.c), 64'h00);
    bus8.a = 8'h5A; bus8.s = 1'b1; bus2.s = 1'b1; #1;
    chk("mid_c_a", 64'(bus8.c), 64'h5A);
    @(posedge clk); #1;
    chk("mid_hold_cq8", 64'(bus8.c_q), 64'h0);
    chk("mid_hold_cnt", 64'(bus8.sel_toggles), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_sq  = 1'b0;
    m_cnt = 16'h0;

    // First edge after reset with s=1 counts once
    step("post1", 8'h3C, 8'h81, 1'b1);
    step("post2", 8'h3C, 8'h81, 1'b0);

    // A handful of random patterns
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      step("rnd", ra, rb, rs);
    end

    // Force many edge-sampled changes to drive the counter into saturation
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      bus8.s = ~bus8.s;
      bus2.s = bus8.s;
      model_edge(bus8.s);
    end
    @(posedge clk); #1;
    chk("sat_model", 64'(bus8.sel_toggles), 64'(m_cnt));
    chk("sat_ffff",  64'(bus8.sel_toggles), 64'hFFFF);
    step("sat_hold", 8'h11, 8'h22, ~bus8.s);
    chk("sat_still", 64'(bus8.sel_toggles), 64'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
